// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with 5..9 data bits, optional even/odd parity and one or two stop bits.
// Each bit is decided by a 2-of-3 majority vote around mid-bit; good words go to P_DATA, bad frames pulse error flags.
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int BW = (DATA_WIDTH > 8) ? 4 : 3;
    localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
    logic                   dv_q, dv_d;
    logic                   pe_q, pe_d;
    logic                   se_q, se_d;
    logic                   busy_q, busy_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [1:0]             samp_q, samp_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   stop2_q, stop2_d;
    logic [PRESCALE_W-1:0]  presc_q, presc_d;
    logic                   par_bad_q, par_bad_d;
    logic                   stop_bad_q, stop_bad_d;

    logic [PRESCALE_W-1:0]  half;
    logic                   at_s0, at_s1, at_dec, at_term;
    logic                   bit_val, stop_fail, presc_legal, finish;

    assign half        = presc_q >> 1;
    assign at_s0       = (edge_cnt_q == half - ONE);
    assign at_s1       = (edge_cnt_q == half);
    assign at_dec      = (edge_cnt_q == half + ONE);
    assign at_term     = (edge_cnt_q == presc_q - ONE);
    // Third vote is the live line value at the decision count.
    assign bit_val     = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);
    assign stop_fail   = stop_bad_q | ~bit_val;
    assign presc_legal = (32'(Prescale) >= 32'd8) && !Prescale[0];

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shadow_d   = shadow_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        rx_prev_d  = RX_IN;
        samp_d     = samp_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        presc_d    = presc_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        finish     = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = at_term ? '0 : edge_cnt_q + ONE;
            if (at_s0) samp_d[0] = RX_IN;
            if (at_s1) samp_d[1] = RX_IN;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                // Only a true high-to-low transition starts a frame.
                if (rx_prev_q && !RX_IN && presc_legal) begin
                    state_d    = S_START;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop2_d    = STOP2;
                    presc_d    = Prescale;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (at_dec && bit_val) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (at_term) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) shadow_d = {bit_val, shadow_q[DATA_WIDTH-1:1]};
                if (at_term) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_dec) par_bad_d = bit_val ^ (^shadow_q) ^ par_typ_q;
                if (at_term) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (at_dec) begin
                    stop_bad_d = stop_fail;
                    if (!stop2_q) finish = 1'b1;
                end
                if (at_term && stop2_q) state_d = S_STOP2;
            end
            S_STOP2: begin
                if (at_dec) finish = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Leave at the final stop decision so the next start edge is seen early.
        if (finish) begin
            state_d    = S_IDLE;
            edge_cnt_d = '0;
            if (par_bad_q || stop_fail) begin
                pe_d = par_bad_q;
                se_d = stop_fail;
            end else begin
                p_data_d = shadow_q;
                dv_d     = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shadow_q   <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_prev_q  <= 1'b0;
            samp_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            presc_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shadow_q   <= shadow_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            busy_q     <= busy_d;
            rx_prev_q  <= rx_prev_d;
            samp_q     <= samp_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            presc_q    <= presc_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_valid = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8-bit and a 7-bit receiver fed serial frames built from the
// frame rules (start, LSB-first data, parity, stops); outcomes predicted from those rules.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic [5:0] presc = 6'd8;

    logic [7:0] pd8;
    logic       dv8, pe8, se8, busy8;
    logic [6:0] pd7;
    logic       dv7, pe7, se7, busy7;

    int total = 0;
    int bad = 0;

    int dv_cnt8 = 0, pe_cnt8 = 0, se_cnt8 = 0, busy_cnt8 = 0, long_cnt8 = 0;
    int dv_cnt7 = 0, pe_cnt7 = 0, se_cnt7 = 0, long_cnt7 = 0;
    logic dv8_prev = 1'b0, dv7_prev = 1'b0;
    logic [7:0] got8 [0:255];
    logic [6:0] got7 [0:255];
    logic [7:0] last_good8 = 8'h00;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(presc), .P_DATA(pd8), .Data_valid(dv8),
        .PAR_ERR(pe8), .STP_ERR(se8), .Busy(busy8)
    );

    uart_rx_param #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx7), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(presc), .P_DATA(pd7), .Data_valid(dv7),
        .PAR_ERR(pe7), .STP_ERR(se7), .Busy(busy7)
    );

    // Pulse monitor: records every received word and counts flag pulses.
    always @(negedge clk) begin
        if (dv8) begin
            got8[dv_cnt8 % 256] = pd8;
            dv_cnt8++;
        end
        if (dv8 && dv8_prev) long_cnt8++;
        dv8_prev = dv8;
        if (pe8) pe_cnt8++;
        if (se8) se_cnt8++;
        if (busy8) busy_cnt8++;
        if (dv7) begin
            got7[dv_cnt7 % 256] = pd7;
            dv_cnt7++;
        end
        if (dv7 && dv7_prev) long_cnt7++;
        dv7_prev = dv7;
        if (pe7) pe_cnt7++;
        if (se7) se_cnt7++;
    end

    task automatic drive(input int which, input logic v, input int cycles);
        if (which == 8) rx8 = v;
        else rx7 = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Serial frame generator; presc_in < 0 uses p and scrambles config after the start edge.
    task automatic send_frame(input int which, input int w, input logic [8:0] d, input int p,
                              input bit pen, input bit ptyp, input bit s2, input bit flip_par,
                              input bit bad_stop, input int gap, input int presc_in);
        logic [8:0] dm;
        logic       pb;
        dm      = d & 9'((1 << w) - 1);
        pb      = logic'(($countones(dm) % 2) != 0) ^ ptyp ^ flip_par;
        par_en  = pen;
        par_typ = ptyp;
        stop2   = s2;
        presc   = (presc_in < 0) ? 6'(p) : 6'(presc_in);
        $display("frame dut=%0d data=%h p=%0d pen=%0d ptyp=%0d s2=%0d flip_par=%0d bad_stop=%0d",
                 which, dm, p, pen, ptyp, s2, flip_par, bad_stop);
        drive(which, 1'b0, 1);
        if (presc_in < 0) begin
            par_en  = 1'($urandom_range(0, 1));
            par_typ = 1'($urandom_range(0, 1));
            stop2   = 1'($urandom_range(0, 1));
            presc   = 6'($urandom_range(0, 63));
        end
        drive(which, 1'b0, p - 1);
        for (int i = 0; i < w; i++) drive(which, dm[i], p);
        if (pen) drive(which, pb, p);
        drive(which, !bad_stop, p);
        if (s2) drive(which, 1'b1, p);
        drive(which, 1'b1, gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx8 = 1'b0;
        rx7 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pd8 !== 8'h00) begin bad++; $display("FAIL reset_pdata8 got=%h exp=00", pd8); end
        total++; if (dv8 !== 1'b0) begin bad++; $display("FAIL reset_dv8 got=%b exp=0", dv8); end
        total++; if (pe8 !== 1'b0 || se8 !== 1'b0) begin bad++; $display("FAIL reset_err8 got=%b%b exp=00", pe8, se8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        total++; if (pd7 !== 7'h00 || dv7 !== 1'b0 || busy7 !== 1'b0) begin bad++; $display("FAIL reset_dut7 got=%h/%b/%b exp=00/0/0", pd7, dv7, busy7); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // Line already low at release: no frame may start without a falling edge.
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_no_edge_busy got=%b exp=0", busy8); end
        rx8 = 1'b1;
        rx7 = 1'b1;
        repeat (4) @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_8n1;
        int dv0, pe0, se0, l0;
        dv0 = dv_cnt8; pe0 = pe_cnt8; se0 = se_cnt8; l0 = long_cnt8;
        send_frame(8, 8, 9'h0A5, 8, 0, 0, 0, 0, 0, 10, -1);
        last_good8 = 8'hA5;
        total++; if (dv_cnt8 - dv0 !== 1) begin bad++; $display("FAIL 8n1_dv_count got=%0d exp=1", dv_cnt8 - dv0); end
        total++; if (got8[dv0 % 256] !== 8'hA5) begin bad++; $display("FAIL 8n1_word got=%h exp=a5", got8[dv0 % 256]); end
        total++; if (pe_cnt8 - pe0 + se_cnt8 - se0 !== 0) begin bad++; $display("FAIL 8n1_errors got=%0d exp=0", pe_cnt8 - pe0 + se_cnt8 - se0); end
        total++; if (long_cnt8 - l0 !== 0) begin bad++; $display("FAIL 8n1_pulse_width got=%0d exp=0", long_cnt8 - l0); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL 8n1_busy_after got=%b exp=0", busy8); end
    endtask

    task automatic test_parity_err;
        int dv0, pe0, se0;
        dv0 = dv_cnt8; pe0 = pe_cnt8; se0 = se_cnt8;
        send_frame(8, 8, 9'h003, 16, 1, 0, 0, 1, 0, 10, -1);
        total++; if (pe_cnt8 - pe0 !== 1) begin bad++; $display("FAIL parity_err_pulse got=%0d exp=1", pe_cnt8 - pe0); end
        total++; if (dv_cnt8 - dv0 !== 0 || se_cnt8 - se0 !== 0) begin bad++; $display("FAIL parity_no_dv got=%0d/%0d exp=0/0", dv_cnt8 - dv0, se_cnt8 - se0); end
        total++; if (pd8 !== last_good8) begin bad++; $display("FAIL parity_pdata_kept got=%h exp=%h", pd8, last_good8); end
    endtask

    task automatic test_stop_err;
        int dv0, pe0, se0;
        dv0 = dv_cnt8; pe0 = pe_cnt8; se0 = se_cnt8;
        send_frame(8, 8, 9'h05A, 8, 0, 0, 0, 0, 1, 12, -1);
        total++; if (se_cnt8 - se0 !== 1) begin bad++; $display("FAIL stop_err_pulse got=%0d exp=1", se_cnt8 - se0); end
        total++; if (dv_cnt8 - dv0 !== 0 || pe_cnt8 - pe0 !== 0) begin bad++; $display("FAIL stop_no_dv got=%0d/%0d exp=0/0", dv_cnt8 - dv0, pe_cnt8 - pe0); end
        total++; if (pd8 !== last_good8) begin bad++; $display("FAIL stop_pdata_kept got=%h exp=%h", pd8, last_good8); end
        send_frame(8, 8, 9'h011, 8, 0, 0, 0, 0, 0, 10, -1);
        last_good8 = 8'h11;
        total++; if (dv_cnt8 - dv0 !== 1 || pd8 !== 8'h11) begin bad++; $display("FAIL stop_recover got=%0d/%h exp=1/11", dv_cnt8 - dv0, pd8); end
    endtask

    task automatic test_glitch;
        int dv0, pe0, se0;
        dv0 = dv_cnt8; pe0 = pe_cnt8; se0 = se_cnt8;
        presc = 6'd16;
        drive(8, 1'b0, 2);
        drive(8, 1'b1, 2);
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL glitch_busy_in_start got=%b exp=1", busy8); end
        drive(8, 1'b1, 20);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL glitch_busy_drop got=%b exp=0", busy8); end
        total++; if (dv_cnt8 - dv0 + pe_cnt8 - pe0 + se_cnt8 - se0 !== 0) begin bad++; $display("FAIL glitch_no_pulse got=%0d exp=0", dv_cnt8 - dv0 + pe_cnt8 - pe0 + se_cnt8 - se0); end
        $display("glitch done");
    endtask

    task automatic test_illegal_prescale;
        int dv0, b0;
        dv0 = dv_cnt8; b0 = busy_cnt8;
        send_frame(8, 8, 9'h055, 8, 0, 0, 0, 0, 0, 8, 9);
        send_frame(8, 8, 9'h0AA, 8, 0, 0, 0, 0, 0, 8, 6);
        total++; if (busy_cnt8 - b0 !== 0) begin bad++; $display("FAIL illegal_presc_busy got=%0d exp=0", busy_cnt8 - b0); end
        total++; if (dv_cnt8 - dv0 !== 0) begin bad++; $display("FAIL illegal_presc_dv got=%0d exp=0", dv_cnt8 - dv0); end
    endtask

    task automatic test_back_to_back7;
        int dv0, pe0, se0, l0;
        dv0 = dv_cnt7; pe0 = pe_cnt7; se0 = se_cnt7; l0 = long_cnt7;
        send_frame(7, 7, 9'h041, 10, 1, 1, 1, 0, 0, 0, -1);
        send_frame(7, 7, 9'h07F, 10, 1, 1, 1, 0, 0, 20, -1);
        total++; if (dv_cnt7 - dv0 !== 2) begin bad++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt7 - dv0); end
        total++; if (got7[dv0 % 256] !== 7'h41) begin bad++; $display("FAIL b2b_word0 got=%h exp=41", got7[dv0 % 256]); end
        total++; if (got7[(dv0 + 1) % 256] !== 7'h7F) begin bad++; $display("FAIL b2b_word1 got=%h exp=7f", got7[(dv0 + 1) % 256]); end
        total++; if (pe_cnt7 - pe0 + se_cnt7 - se0 !== 0 || long_cnt7 - l0 !== 0) begin bad++; $display("FAIL b2b_errors got=%0d/%0d exp=0/0", pe_cnt7 - pe0 + se_cnt7 - se0, long_cnt7 - l0); end
    endtask

    task automatic test_random;
        int dv0, pe0, se0, n_exp, n_pe, n_se, p, gap;
        logic [7:0] exp_w [0:31];
        logic [8:0] d;
        bit pen, ptyp, s2, fp, bs;
        dv0 = dv_cnt8; pe0 = pe_cnt8; se0 = se_cnt8;
        n_exp = 0; n_pe = 0; n_se = 0;
        for (int f = 0; f < 24; f++) begin
            p    = 8 + 2 * int'($urandom_range(0, 4));
            d    = 9'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            fp   = pen && ($urandom_range(0, 4) == 0);
            bs   = ($urandom_range(0, 5) == 0);
            gap  = int'($urandom_range(2, 6));
            send_frame(8, 8, d, p, pen, ptyp, s2, fp, bs, gap, -1);
            if (fp) n_pe++;
            if (bs) n_se++;
            if (!fp && !bs) begin
                exp_w[n_exp] = d[7:0];
                n_exp++;
            end
        end
        drive(8, 1'b1, 10);
        total++; if (dv_cnt8 - dv0 !== n_exp) begin bad++; $display("FAIL random_dv_count got=%0d exp=%0d", dv_cnt8 - dv0, n_exp); end
        total++; if (pe_cnt8 - pe0 !== n_pe) begin bad++; $display("FAIL random_pe_count got=%0d exp=%0d", pe_cnt8 - pe0, n_pe); end
        total++; if (se_cnt8 - se0 !== n_se) begin bad++; $display("FAIL random_se_count got=%0d exp=%0d", se_cnt8 - se0, n_se); end
        for (int i = 0; i < n_exp && i < dv_cnt8 - dv0; i++) begin
            total++;
            if (got8[(dv0 + i) % 256] !== exp_w[i]) begin
                bad++;
                $display("FAIL random_word%0d got=%h exp=%h", i, got8[(dv0 + i) % 256], exp_w[i]);
            end
        end
        if (n_exp > 0) last_good8 = exp_w[n_exp - 1];
        total++; if (pd8 !== last_good8) begin bad++; $display("FAIL random_final_pdata got=%h exp=%h", pd8, last_good8); end
    endtask

    task automatic test_reset_mid;
        int dv0, pe0, se0;
        logic [7:0] d;
        dv0 = dv_cnt8; pe0 = pe_cnt8; se0 = se_cnt8;
        d = 8'hC3;
        par_en = 1'b0; stop2 = 1'b0; presc = 6'd8;
        drive(8, 1'b0, 8);
        for (int i = 0; i < 3; i++) drive(8, d[i], 8);
        drive(8, d[3], 4);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (pd8 !== 8'h00 || dv8 !== 1'b0 || pe8 !== 1'b0 || se8 !== 1'b0 || busy8 !== 1'b0)
            begin bad++; $display("FAIL midreset_outputs got=%h/%b%b%b/%b exp=00/000/0", pd8, dv8, pe8, se8, busy8); end
        rst_n = 1'b1;
        last_good8 = 8'h00;
        drive(8, 1'b1, 40);
        total++; if (dv_cnt8 - dv0 + pe_cnt8 - pe0 + se_cnt8 - se0 !== 0) begin bad++; $display("FAIL midreset_no_pulse got=%0d exp=0", dv_cnt8 - dv0 + pe_cnt8 - pe0 + se_cnt8 - se0); end
        send_frame(8, 8, 9'h0C3, 8, 0, 0, 0, 0, 0, 10, -1);
        last_good8 = 8'hC3;
        total++; if (dv_cnt8 - dv0 !== 1 || pd8 !== 8'hC3) begin bad++; $display("FAIL midreset_recover got=%0d/%h exp=1/c3", dv_cnt8 - dv0, pd8); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_err();
        test_stop_err();
        test_glitch();
        test_illegal_prescale();
        test_back_to_back7();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
